// File: rtl/mont_const_gen_if.sv
// Request/result bundle for mont_const_gen.
// Optional nprime result present only when MONT_NPRIME_EN is defined.
interface mont_const_gen_if #(
  parameter int WIDTH = 1024,
  parameter int NPW   = 32
);
  logic             start;
  logic [WIDTH-1:0] M_r;
  logic [WIDTH-1:0] R_r;
  logic [WIDTH-1:0] R_t;
`ifdef MONT_NPRIME_EN
  logic [NPW-1:0]   nprime;
`endif
  logic             busy;
  logic             done;
  logic             err;

  // n' width must lie within the modulus width
  if (NPW < 1 || NPW > WIDTH) begin : g_npw_chk
    $error("mont_const_gen_if: NPW out of range");
  end

  modport master (
    output start, M_r,
    input  R_r, R_t,
`ifdef MONT_NPRIME_EN
    input  nprime,
`endif
    input  busy, done, err
  );

  modport slave (
    input  start, M_r,
    output R_r, R_t,
`ifdef MONT_NPRIME_EN
    output nprime,
`endif
    output busy, done, err
  );
endinterface

// File: rtl/mont_const_gen.sv
// Bit-serial Montgomery constant generator: R mod M and R^2 mod M, R = 2^WIDTH.
// One modular doubling per cycle over 2*WIDTH cycles.
// Optional n' = -M^-1 mod 2^NPW via a Hensel lift when MONT_NPRIME_EN is defined.
module mont_const_gen #(
  parameter int WIDTH = 1024,
  parameter int NPW   = 32
) (
  input  logic           clk,
  input  logic           reset,
  mont_const_gen_if.slave bus
);
  localparam int CW = $clog2(2 * WIDTH);

  if (WIDTH < 4) begin : g_width_chk
    $error("mont_const_gen: WIDTH must be at least 4");
  end
  if (NPW < 1 || NPW > WIDTH) begin : g_npw_chk
    $error("mont_const_gen: NPW out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   r, r2, r_nxt;
  logic [CW-1:0]    cnt;
  logic             m_ok, at_rr, at_rt;

  // odd and >= 3 is the same as odd and not 1
  assign m_ok  = bus.M_r[0] && (bus.M_r != WIDTH'(1));
  assign at_rr = (cnt == CW'(WIDTH - 1));
  assign at_rt = (cnt == CW'(2 * WIDTH - 1));

  // Modular doubling: r < M keeps 2r < 2M, so one conditional subtract suffices
  always_comb begin
    r2    = r << 1;
    r_nxt = (r2 >= {1'b0, m}) ? (r2 - {1'b0, m}) : r2;
  end

`ifdef MONT_NPRIME_EN
  logic [NPW-1:0] a, t, a_nxt, t_nxt, m_sh;
  logic           h_act;

  // Hensel step: force bit cnt of a = M*t to one, recording the chosen bit in t
  always_comb begin
    m_sh  = m[NPW-1:0] << cnt;
    h_act = (state == RUN) && (cnt < CW'(NPW));
    a_nxt = a;
    t_nxt = t;
    if (h_act && ((a & (NPW'(1) << cnt)) == '0)) begin
      a_nxt = a + m_sh;
      t_nxt = t | (NPW'(1) << cnt);
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: rejected moduli skip straight to FIN so err is reported via done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = m_ok ? RUN : FIN;
      RUN:     if (at_rt) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers; results hold from done until the next accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      m        <= '0;
      r        <= '0;
      cnt      <= '0;
      bus.R_r  <= '0;
      bus.R_t  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
`ifdef MONT_NPRIME_EN
      a          <= '0;
      t          <= '0;
      bus.nprime <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          m        <= bus.M_r;
          r        <= (WIDTH+1)'(1);
          cnt      <= '0;
          bus.R_r  <= '0;
          bus.R_t  <= '0;
          bus.err  <= !m_ok;
          bus.busy <= 1'b1;
`ifdef MONT_NPRIME_EN
          a          <= '0;
          t          <= '0;
          bus.nprime <= '0;
`endif
        end
        RUN: begin
          r   <= r_nxt;
          cnt <= cnt + CW'(1);
          if (at_rr) bus.R_r <= r_nxt[WIDTH-1:0];
          if (at_rt) bus.R_t <= r_nxt[WIDTH-1:0];
`ifdef MONT_NPRIME_EN
          a <= a_nxt;
          t <= t_nxt;
          if (cnt == CW'(NPW - 1)) bus.nprime <= t_nxt;
`endif
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_const_gen.sv
// Scoreboard bench for mont_const_gen: 8-bit and 1024-bit instances.
// Expected constants come from wide-integer modulo and Newton inversion.
module tb_mont_const_gen;
  localparam int WN = 8;
  localparam int NN = 8;
  localparam int WW = 1024;
  localparam int NW = 32;
  localparam int BW = 2 * WW + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mont_const_gen_if #(.WIDTH(WN), .NPW(NN)) if8 ();
  mont_const_gen_if #(.WIDTH(WW), .NPW(NW)) ifw ();

  mont_const_gen #(.WIDTH(WN), .NPW(NN)) dut8 (.clk(clk), .reset(reset), .bus(if8));
  mont_const_gen #(.WIDTH(WW), .NPW(NW)) dutw (.clk(clk), .reset(reset), .bus(ifw));

  typedef struct {
    logic [WW-1:0] rr;
    logic [WW-1:0] rt;
    logic [31:0]   np;
    bit            err;
    int            lat;
    int            t0;
  } exp_t;

  exp_t q8[$];
  exp_t qw[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp_v);
    end
  endtask

  // Reference: R mod M and R^2 mod M by wide-integer modulo; n' by Newton inversion
  function automatic exp_t model(input int w, input int npw, input logic [WW-1:0] m, input int t0);
    exp_t e;
    logic [BW-1:0] mm, big;
    logic [31:0] inv, m32, mask;
    e.t0 = t0;
    if (!m[0] || m == WW'(1)) begin
      e.err = 1'b1; e.rr = '0; e.rt = '0; e.np = '0; e.lat = 2;
    end else begin
      mm  = BW'(m);
      big = BW'(1) << w;
      e.rr = WW'(big % mm);
      big = BW'(1) << (2 * w);
      e.rt = WW'(big % mm);
      m32 = m[31:0];
      inv = m32;
      repeat (5) inv = inv * (32'd2 - m32 * inv);
      mask = (npw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << npw) - 32'd1);
      e.np  = (32'd0 - inv) & mask;
      e.err = 1'b0;
      e.lat = 2 * w + 2;
    end
    return e;
  endfunction

  // Monitor, 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (if8.done) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL n8_unexpected_done got=1 want=0");
      end else begin
        e = q8.pop_front();
        chk("n8_R_r", WW'(if8.R_r), e.rr);
        chk("n8_R_t", WW'(if8.R_t), e.rt);
        chk("n8_err", WW'(if8.err), WW'(e.err));
`ifdef MONT_NPRIME_EN
        chk("n8_nprime", WW'(if8.nprime), WW'(e.np));
`endif
        chk("n8_latency", WW'(cyc - e.t0), WW'(e.lat));
        chk("n8_busy_at_done", WW'(if8.busy), '0);
      end
    end
  end

  // Monitor, 1024-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (ifw.done) begin
      if (qw.size() == 0) begin
        total++; bad++;
        $display("FAIL nw_unexpected_done got=1 want=0");
      end else begin
        e = qw.pop_front();
        chk("nw_R_r", ifw.R_r, e.rr);
        chk("nw_R_t", ifw.R_t, e.rt);
        chk("nw_err", WW'(ifw.err), WW'(e.err));
`ifdef MONT_NPRIME_EN
        chk("nw_nprime", WW'(ifw.nprime), WW'(e.np));
`endif
        chk("nw_latency", WW'(cyc - e.t0), WW'(e.lat));
        chk("nw_busy_at_done", WW'(ifw.busy), '0);
      end
    end
  end

  // Call at a negedge with the target idle; leaves at the negedge after the start edge
  task automatic issue(input bit wide, input logic [WW-1:0] m);
    if (wide) begin
      ifw.start = 1'b1; ifw.M_r = m;
      qw.push_back(model(WW, NW, m, cyc));
    end else begin
      if8.start = 1'b1; if8.M_r = m[WN-1:0];
      q8.push_back(model(WN, NN, WW'(m[WN-1:0]), cyc));
    end
    @(negedge clk);
    if8.start = 1'b0;
    ifw.start = 1'b0;
  endtask

  // Wait for done, checking busy stays high until then; returns at the done negedge
  task automatic wait_done(input bit wide);
    int n = 0;
    int budget;
    bit busy_ok = 1'b1;
    budget = wide ? 2 * WW + 10 : 2 * WN + 10;
    while (!(wide ? ifw.done : if8.done) && n <= budget) begin
      if (!(wide ? ifw.busy : if8.busy)) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n > budget) begin
      total++; bad++;
      $display("FAIL done_timeout got=%0d want<=%0d", n, budget);
    end
    chk(wide ? "nw_busy_while_running" : "n8_busy_while_running", WW'(busy_ok), WW'(1));
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_R_r"}, WW'(if8.R_r), '0);
    chk({tag, "_R_t"}, WW'(if8.R_t), '0);
    chk({tag, "_busy"}, WW'(if8.busy), '0);
    chk({tag, "_done"}, WW'(if8.done), '0);
    chk({tag, "_err"}, WW'(if8.err), '0);
`ifdef MONT_NPRIME_EN
    chk({tag, "_nprime"}, WW'(if8.nprime), '0);
`endif
  endtask

  initial begin
    logic [WW-1:0] mw;
    logic [WW-1:0] m8;
    if8.start = 1'b0; if8.M_r = '0;
    ifw.start = 1'b0; ifw.M_r = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_zero("rst");
    chk("rst_w_busy", WW'(ifw.busy), '0);
    chk("rst_w_R_t", ifw.R_t, '0);

    // M=13: 9 / 3, n'=59
    issue(0, WW'(13)); wait_done(0);
    chk("m13_R_r_const", WW'(if8.R_r), WW'(9));
    chk("m13_R_t_const", WW'(if8.R_t), WW'(3));

    // M=255 then M=251 issued while done is still high
    issue(0, WW'(255)); wait_done(0);
    issue(0, WW'(251)); wait_done(0);
    chk("m251_R_t_const", WW'(if8.R_t), WW'(25));

    // rejected moduli, then a valid one clears err
    issue(0, WW'(12)); wait_done(0);
    issue(0, WW'(1));  wait_done(0);
    chk("m1_err_held", WW'(if8.err), WW'(1));
    issue(0, WW'(13)); wait_done(0);

    // start re-pulsed at cnt=5 with M_r changed to 11: ignored
    issue(0, WW'(13));
    repeat (5) @(negedge clk);
    if8.start = 1'b1; if8.M_r = 8'd11;
    @(negedge clk);
    if8.start = 1'b0;
    wait_done(0);

    // reset at cnt=10 aborts with no done pulse
    issue(0, WW'(13));
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q8.delete();
    check_idle_zero("abort");
    repeat (30) @(negedge clk);
    issue(0, WW'(13)); wait_done(0);

    // start together with reset: start dropped
    reset = 1'b1; if8.start = 1'b1; if8.M_r = 8'd13;
    @(negedge clk);
    reset = 1'b0; if8.start = 1'b0;
    check_idle_zero("rst_start");
    repeat (25) @(negedge clk);

    // random moduli, mostly odd, random idle gaps
    for (int i = 0; i < 40; i++) begin
      m8 = WW'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) m8[0] = 1'b1;
      issue(0, m8); wait_done(0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 1024-bit: fixed modulus, a random one, and an even one
    mw = {32{32'hC3A5_9E17}};
    mw[WW-1] = 1'b1; mw[0] = 1'b1;
    issue(1, mw); wait_done(1);
    for (int k = 0; k < WW / 32; k++) mw[k*32 +: 32] = $urandom;
    mw[WW-1] = 1'b1; mw[0] = 1'b1;
    issue(1, mw); wait_done(1);
    mw[0] = 1'b0;
    issue(1, mw); wait_done(1);

    repeat (5) @(negedge clk);
    chk("q8_drained", WW'(q8.size()), '0);
    chk("qw_drained", WW'(qw.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
